// File: rtl/mem_bus_if.sv
// Multiplexed address/data memory bus master.
// A request sampled in IDLE runs an ADDR, SETUP, DATA (wait-extended), FINISH
// sequence on the pads. Every output comes straight from a flop; the output
// flops are loaded from the next state, so they change together with the state.
module mem_bus_if #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              nwait_i,
  input  logic [DATA_W-1:0] adin_i,
  output logic [DATA_W-1:0] adout_o,
  output logic              adoe_o,
  output logic              ale_o,
  output logic              nme_o,
  output logic              noe_o,
  output logic              nwe_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ack_o,
  output logic              busy_o,
  output logic              buserr_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [3:0] WAIT_MAX = 4'd15;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              tmo_q, tmo_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] adout_q, adout_d;
  logic              adoe_q, adoe_d;
  logic              ale_q, ale_d;
  logic              nme_q, nme_d;
  logic              noe_q, noe_d;
  logic              nwe_q, nwe_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              buserr_q, buserr_d;

  // Next-state, capture and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        // Request fields are only looked at here, so changes while busy are ignored.
        if (req_i) begin
          wr_d    = wr_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          tmo_d   = 1'b0;
          state_d = S_ADDR;
        end
      end
      S_ADDR:  state_d = S_SETUP;
      S_SETUP: begin
        cnt_d   = 4'd0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (nwait_i) begin
          if (!wr_q) rdata_d = adin_i;
          state_d = S_FINISH;
        end else if (cnt_q == WAIT_MAX) begin
          // Sixteenth stalled DATA cycle: give up, keep the old read data.
          tmo_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Pad and handshake outputs decoded from the state being entered.
  always_comb begin
    ale_d    = 1'b0;
    nme_d    = 1'b1;
    noe_d    = 1'b1;
    nwe_d    = 1'b1;
    adoe_d   = 1'b0;
    adout_d  = adout_q;
    ack_d    = 1'b0;
    buserr_d = 1'b0;
    busy_d   = (state_d != S_IDLE);
    case (state_d)
      S_ADDR: begin
        ale_d   = 1'b1;
        adoe_d  = 1'b1;
        adout_d = addr_d;
      end
      S_SETUP: begin
        nme_d   = 1'b0;
        adoe_d  = 1'b1;
        adout_d = addr_d;
      end
      S_DATA: begin
        nme_d = 1'b0;
        if (wr_d) begin
          nwe_d   = 1'b0;
          adoe_d  = 1'b1;
          adout_d = wdata_d;
        end else begin
          noe_d = 1'b0;
        end
      end
      S_FINISH: begin
        ack_d    = 1'b1;
        buserr_d = tmo_d;
      end
      default: ;
    endcase
  end

  // State, capture and output registers; reset returns everything to idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      tmo_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      adout_q  <= '0;
      adoe_q   <= 1'b0;
      ale_q    <= 1'b0;
      nme_q    <= 1'b1;
      noe_q    <= 1'b1;
      nwe_q    <= 1'b1;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      adout_q  <= adout_d;
      adoe_q   <= adoe_d;
      ale_q    <= ale_d;
      nme_q    <= nme_d;
      noe_q    <= noe_d;
      nwe_q    <= nwe_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      buserr_q <= buserr_d;
    end
  end

  assign adout_o  = adout_q;
  assign adoe_o   = adoe_q;
  assign ale_o    = ale_q;
  assign nme_o    = nme_q;
  assign noe_o    = noe_q;
  assign nwe_o    = nwe_q;
  assign rdata_o  = rdata_q;
  assign ack_o    = ack_q;
  assign busy_o   = busy_q;
  assign buserr_o = buserr_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Scoreboard bench for mem_bus_if: a stimulus process issues transactions and
// pushes expected results; a memory-device process answers the bus; a monitor
// process checks pad activity and completions against the queue.
module tb_mem_bus_if;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0, wr_i = 1'b0, nwait_i = 1'b1;
  logic [15:0] addr_i = '0, wdata_i = '0, adin_i = '0;
  logic [15:0] adout_o, rdata_o;
  logic        adoe_o, ale_o, nme_o, noe_o, nwe_o, ack_o, busy_o, buserr_o;

  mem_bus_if #(.DATA_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .wr_i(wr_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .nwait_i(nwait_i), .adin_i(adin_i), .adout_o(adout_o),
    .adoe_o(adoe_o), .ale_o(ale_o), .nme_o(nme_o), .noe_o(noe_o), .nwe_o(nwe_o),
    .rdata_o(rdata_o), .ack_o(ack_o), .busy_o(busy_o), .buserr_o(buserr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
    int          ale_cyc;
    int          ack_cyc;
  } exp_t;

  exp_t        sb[$];
  int          nchk = 0, npass = 0;
  int          cyc = 0;
  int          acks = 0;
  int          cur_waits = 0;
  logic [15:0] adin_base = '0;
  logic [15:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act === req) npass++;
    else $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory device: holds nWait low for the first cur_waits strobe cycles and
  // presents a different AdIn value on every strobe cycle.
  int dk = 0;
  always @(negedge clk) begin
    if (!noe_o || !nwe_o) begin
      nwait_i = (dk >= cur_waits);
      adin_i  = adin_base + 16'(dk);
      dk++;
    end else begin
      dk = 0;
      nwait_i = 1'($urandom);
      adin_i  = 16'($urandom);
    end
  end

  // Monitor: pad sequencing of the transaction at the head of the queue,
  // strobe exclusivity every cycle, and completion results.
  always @(negedge clk) begin
    if (!rst_i) begin
      chk("noe_nwe_excl", {31'd0, noe_o | nwe_o}, 32'd1);
      chk("ale_nme_excl", {31'd0, ale_o & ~nme_o}, 32'd0);
      if (buserr_o && !ack_o) chk("buserr_without_ack", 32'd1, 32'd0);
      if (sb.size() > 0) begin
        if (ale_o) begin
          chk("ale_cycle", cyc, sb[0].ale_cyc);
          chk("ale_addr", {16'd0, adout_o}, {16'd0, sb[0].addr});
          chk("ale_adoe", {31'd0, adoe_o}, 32'd1);
        end
        if (!nme_o && noe_o && nwe_o) begin
          chk("setup_addr", {16'd0, adout_o}, {16'd0, sb[0].addr});
          chk("setup_adoe", {31'd0, adoe_o}, 32'd1);
        end
        if (!nwe_o) begin
          chk("wr_kind", {31'd0, sb[0].wr}, 32'd1);
          chk("wr_data", {16'd0, adout_o}, {16'd0, sb[0].wdata});
          chk("wr_adoe", {31'd0, adoe_o}, 32'd1);
        end
        if (!noe_o) begin
          chk("rd_kind", {31'd0, sb[0].wr}, 32'd0);
          chk("rd_adoe", {31'd0, adoe_o}, 32'd0);
        end
      end
      if (ack_o) begin
        acks++;
        if (sb.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_cycle", cyc, e.ack_cyc);
          chk("buserr", {31'd0, buserr_o}, {31'd0, e.err});
          chk("rdata", {16'd0, rdata_o}, {16'd0, e.rdata});
          chk("ack_adoe", {31'd0, adoe_o}, 32'd0);
          chk("ack_busy", {31'd0, busy_o}, 32'd1);
        end
      end
    end
  end

  // Issue one transaction at the first idle cycle; waits >= 16 means the
  // device never releases nWait. Expected results come from the bus rules:
  // DATA lasts waits+1 cycles (16 on timeout), ALE follows the Req sample by
  // one edge and Ack appears 2 + DATA cycles after ALE.
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input int waits, input logic [15:0] base);
    exp_t e;
    int   t, dcyc;
    t = 0;
    while (busy_o && t < 60) begin @(negedge clk); t++; end
    if (t >= 60) chk("idle_timeout", 32'd1, 32'd0);
    req_i = 1'b1; wr_i = w; addr_i = a; wdata_i = d;
    cur_waits = waits; adin_base = base;
    dcyc = (waits >= 16) ? 16 : waits + 1;
    e.wr = w; e.addr = a; e.wdata = d; e.err = (waits >= 16);
    if (!w && waits < 16) last_rd = base + 16'(waits);
    e.rdata = last_rd;
    e.ale_cyc = cyc + 1;
    e.ack_cyc = cyc + 1 + 2 + dcyc;
    sb.push_back(e);
    @(negedge clk);
    // Request-side noise while busy must not disturb the transaction.
    t = 0;
    while (busy_o && t < 60) begin
      req_i = 1'($urandom); wr_i = 1'($urandom);
      addr_i = 16'($urandom); wdata_i = 16'($urandom);
      @(negedge clk); t++;
    end
    if (t >= 60) chk("txn_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int t;
    req_i = 1'b0;
    t = 0;
    while (sb.size() > 0 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int t, a0;
    repeat (2) @(negedge clk);
    chk("rst_ale", {31'd0, ale_o}, 32'd0);
    chk("rst_nme", {31'd0, nme_o}, 32'd1);
    chk("rst_noe", {31'd0, noe_o}, 32'd1);
    chk("rst_nwe", {31'd0, nwe_o}, 32'd1);
    chk("rst_adoe", {31'd0, adoe_o}, 32'd0);
    chk("rst_adout", {16'd0, adout_o}, 32'd0);
    chk("rst_rdata", {16'd0, rdata_o}, 32'd0);
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_buserr", {31'd0, buserr_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Directed: plain read, plain write, 3-wait read, timeout read, 15-wait read.
    issue(1'b0, 16'h1234, 16'h0000, 0, 16'hBEEF);
    issue(1'b1, 16'h00A0, 16'h5A5A, 0, 16'h0000);
    issue(1'b0, 16'h0042, 16'h0000, 3, 16'hC000);
    issue(1'b0, 16'h0043, 16'h0000, 20, 16'hD000);
    issue(1'b0, 16'h0044, 16'h0000, 15, 16'hE000);

    // Random traffic, back-to-back with Req effectively held high.
    for (int i = 0; i < 40; i++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 4);
      issue(1'($urandom), 16'($urandom), 16'($urandom), w, 16'($urandom));
    end
    drain();

    // Reset in the DATA phase of a write: bus goes idle, no Ack follows.
    @(negedge clk);
    req_i = 1'b1; wr_i = 1'b1; addr_i = 16'h0777; wdata_i = 16'h1111;
    cur_waits = 20;
    @(negedge clk);
    req_i = 1'b0;
    t = 0;
    while (nwe_o && t < 10) begin @(negedge clk); t++; end
    chk("abort_reached_data", {31'd0, nwe_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    a0 = acks;
    @(negedge clk);
    rst_i = 1'b0;
    chk("abort_nwe", {31'd0, nwe_o}, 32'd1);
    chk("abort_adoe", {31'd0, adoe_o}, 32'd0);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_nme", {31'd0, nme_o}, 32'd1);
    chk("abort_rdata", {16'd0, rdata_o}, 32'd0);
    last_rd = '0;
    repeat (25) @(negedge clk);
    chk("abort_no_ack", acks - a0, 32'd0);

    // After reset: timeout read keeps the cleared RData, then a normal read.
    issue(1'b0, 16'hFFFF, 16'h0000, 17, 16'h2000);
    issue(1'b0, 16'h8000, 16'h0000, 1, 16'h3000);
    drain();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_if.md
MEM_BUS_IF -- requirements
Module: mem_bus_if

Interface
REQ-001 Clock  in  1  single system clock; all state changes on rising edge.
REQ-002 Reset  in  1  synchronous, active-high; sampled on rising edge of Clock.
REQ-003 Req  in  1  transaction request from control FSM; level, sampled only in IDLE.
REQ-004 Wr  in  1  1 = write, 0 = read; captured with Req.
REQ-005 Addr  in  16  word address; captured with Req.
REQ-006 WData  in  16  write data; captured with Req.
REQ-007 nWait  in  1  external wait request, active-low; 0 extends data phase.
REQ-008 AdIn  in  16  multiplexed address/data pad input.
REQ-009 AdOut  out  16  multiplexed address/data pad output.
REQ-010 AdOe  out  1  pad output enable for AdOut.
REQ-011 ALE  out  1  address latch enable, active-high.
REQ-012 nME  out  1  memory enable, active-low.
REQ-013 nOE  out  1  output enable (read strobe), active-low.
REQ-014 nWE  out  1  write enable, active-low.
REQ-015 RData  out  16  captured read data, held until next successful read.
REQ-016 Ack  out  1  one-cycle completion pulse.
REQ-017 Busy  out  1  high in every state except IDLE.
REQ-018 BusErr  out  1  one-cycle pulse coincident with Ack on wait timeout.

Function
REQ-019 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-020 States: IDLE, ADDR, SETUP, DATA, FINISH; 3-bit encoding, unused encodings -> IDLE next cycle.
REQ-021 IDLE: strobes inactive (ALE=0, nME=nOE=nWE=1), AdOe=0; Req=1 -> capture Wr/Addr/WData, go ADDR.
REQ-022 ADDR (1 cycle): ALE=1, AdOut=captured Addr, AdOe=1, nME=1; -> SETUP.
REQ-023 SETUP (1 cycle): ALE=0, AdOut=Addr held, AdOe=1, nME=0; clear wait counter; -> DATA.
REQ-024 DATA read: nME=0, nOE=0, AdOe=0; DATA write: nME=0, nWE=0, AdOe=1, AdOut=captured WData.
REQ-025 DATA SHALL last at least 1 cycle; exit to FINISH on first cycle with nWait=1.
REQ-026 In DATA with nWait=0, 4-bit wait counter SHALL increment; at count 15 with nWait still 0 -> FINISH with timeout flag set.
REQ-027 Read: RData SHALL load AdIn on the DATA cycle where nWait=1; on timeout RData SHALL keep its previous value.
REQ-028 FINISH (1 cycle): strobes inactive, AdOe=0, Ack=1, BusErr=timeout flag; -> IDLE unconditionally.
REQ-029 Zero-wait latency: Req sampled in IDLE at edge N -> Ack high in cycle N+4; each wait cycle adds 1.
REQ-030 Req asserted while Busy=1 SHALL be ignored; Addr/Wr/WData changes while Busy SHALL not affect the transaction in flight.
REQ-031 Back-to-back: Req held high through FINISH SHALL start a new transaction from IDLE (one idle cycle between transactions).
REQ-032 nOE and nWE SHALL never be low in the same cycle; ALE and nME=0 SHALL never coincide.

Reset
REQ-033 Reset=1 at any edge, including mid-transaction, SHALL force IDLE next cycle: ALE=0, nME=nOE=nWE=1, AdOe=0, AdOut=0, RData=0, Ack=0, Busy=0, BusErr=0, wait counter=0.
REQ-034 Reset SHALL take priority over Req and nWait in the same cycle.

Verification
REQ-035 Read, nWait=1, Addr=16'h1234, AdIn=16'hBEEF -> ALE cycle with AdOut=1234, nOE low 1 cycle, RData=BEEF, Ack at N+4, BusErr=0.
REQ-036 Write, Addr=16'h00A0, WData=16'h5A5A, nWait=1 -> AdOut=00A0 in ADDR/SETUP, 5A5A with nWE=0 in DATA, AdOe=1 throughout, Ack at N+4.
REQ-037 Read with nWait=0 for 3 cycles then 1 -> DATA lasts 4 cycles, Ack at N+7, RData=AdIn at release cycle.
REQ-038 Read with nWait held 0 -> timeout after 16 DATA cycles, Ack=BusErr=1 same cycle, RData unchanged.
REQ-039 Reset asserted in DATA of a write -> next cycle nWE=1, AdOe=0, Busy=0, no Ack ever issued for that transaction.
REQ-040 Req held high for two transactions, second Req pulsed during first's DATA -> pulse ignored; held Req yields exactly one IDLE cycle between Ack and next ALE.
